// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared state encodings and default timing constants for the PLL reset sequencer
package pll_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    STAGGER   = 3'd2,
    RUN       = 3'd3,
    PLL_RESET = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGGER_CYCLES = 16;
  localparam int DEF_RELOCK_TIMEOUT = 65536;
  localparam int DEF_PLL_RST_CYCLES = 8;

  // A counter that must reach n-1; a parameter of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for a single asynchronous bit
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= {sr[DEPTH-2:0], d};
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - waits for a stable PLL lock, releases core then video resets, re-pulses the PLL on timeout
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int RELOCK_TIMEOUT = DEF_RELOCK_TIMEOUT,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_core,
  output logic       rst_video,
  output logic       ready,
  output logic [7:0] lock_lost_count,
  output logic [2:0] state_dbg
);

  localparam int TO_W = cnt_width(RELOCK_TIMEOUT);
  localparam int ST_W = cnt_width(STABLE_CYCLES);
  localparam int SG_W = cnt_width(STAGGER_CYCLES);
  localparam int PR_W = cnt_width(PLL_RST_CYCLES);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RELOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
  localparam logic [SG_W-1:0] SG_LAST = SG_W'(STAGGER_CYCLES - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);

  state_t          state, next_state;
  logic            lock_s;
  logic [TO_W-1:0] to_cnt;
  logic [ST_W-1:0] st_cnt;
  logic [SG_W-1:0] sg_cnt;
  logic [PR_W-1:0] pr_cnt;
  logic            pll_rst_d, rst_core_d, rst_video_d, ready_d;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  // Each counter only runs while its state persists, so leaving a state always clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      to_cnt          <= '0;
      st_cnt          <= '0;
      sg_cnt          <= '0;
      pr_cnt          <= '0;
      pll_rst         <= 1'b0;
      rst_core        <= 1'b1;
      rst_video       <= 1'b1;
      ready           <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      state     <= next_state;
      to_cnt    <= (state == WAIT_LOCK && next_state == WAIT_LOCK) ? to_cnt + TO_W'(1) : '0;
      st_cnt    <= (state == STABLE    && next_state == STABLE)    ? st_cnt + ST_W'(1) : '0;
      sg_cnt    <= (state == STAGGER   && next_state == STAGGER)   ? sg_cnt + SG_W'(1) : '0;
      pr_cnt    <= (state == PLL_RESET && next_state == PLL_RESET) ? pr_cnt + PR_W'(1) : '0;
      pll_rst   <= pll_rst_d;
      rst_core  <= rst_core_d;
      rst_video <= rst_video_d;
      ready     <= ready_d;
      if (state == RUN && !lock_s && lock_lost_count != 8'hFF)
        lock_lost_count <= lock_lost_count + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: begin
        if (lock_s)                 next_state = STABLE;
        else if (to_cnt == TO_LAST) next_state = PLL_RESET;
      end
      STABLE: begin
        if (!lock_s)                next_state = WAIT_LOCK;
        else if (st_cnt == ST_LAST) next_state = STAGGER;
      end
      STAGGER: begin
        if (!lock_s)                next_state = WAIT_LOCK;
        else if (sg_cnt == SG_LAST) next_state = RUN;
      end
      RUN: begin
        if (!lock_s)                next_state = WAIT_LOCK;
      end
      PLL_RESET: begin
        if (pr_cnt == PR_LAST)      next_state = WAIT_LOCK;
      end
      default:                      next_state = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d   = (next_state == PLL_RESET);
    rst_core_d  = !(next_state == STAGGER || next_state == RUN);
    rst_video_d = (next_state != RUN);
    ready_d     = (next_state == RUN);
  end

  assign state_dbg = state;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on locked (legal >=2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before rst_core release (legal >=1).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16, cycles between rst_core release and rst_video release (legal >=1).
REQ-004 SHALL have parameter RELOCK_TIMEOUT, default 65536, cycles waiting for lock before a PLL reset pulse (legal >=2).
REQ-005 SHALL have parameter PLL_RST_CYCLES, default 8, pll_rst pulse width (legal >=1).
REQ-006 SHALL have port clock, input, 1, free-running board oscillator clock (25 MHz), never a PLL output.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port locked, input, 1, PLL lock flag, asynchronous to clock.
REQ-009 SHALL have port pll_rst, output, 1, active-high reset request to the PLL RST pin.
REQ-010 SHALL have port rst_core, output, 1, active-high reset for the 125/250 MHz serializer domains.
REQ-011 SHALL have port rst_video, output, 1, active-high reset for the 25 MHz pixel domain.
REQ-012 SHALL have port ready, output, 1, high only in RUN.
REQ-013 SHALL have port lock_lost_count, output, 8, saturating count of lock losses while in RUN.
REQ-014 SHALL have port state_dbg, output, 3, current state encoding.

Function
REQ-015 SHALL pass locked through SYNC_STAGES flops; lock_s is the last stage; all decisions use lock_s only.
REQ-016 SHALL implement states WAIT_LOCK, STABLE, STAGGER, RUN, PLL_RESET; all outputs registered.
REQ-017 WAIT_LOCK: rst_core=rst_video=1, pll_rst=0; lock_s=1 -> STABLE with stable counter cleared; else timeout counter increments, at RELOCK_TIMEOUT-1 -> PLL_RESET.
REQ-018 STABLE: lock_s=0 -> WAIT_LOCK, timeout counter cleared; counter reaching STABLE_CYCLES-1 with lock_s=1 -> STAGGER, rst_core=0 from that edge.
REQ-019 STAGGER: rst_core=0, rst_video=1; lock_s=0 -> WAIT_LOCK; after STAGGER_CYCLES cycles -> RUN, rst_video=0 and ready=1 on the same edge.
REQ-020 RUN: lock_s=0 -> WAIT_LOCK; rst_core, rst_video reassert and ready falls on that edge; lock_lost_count increments, saturating at 255.
REQ-021 PLL_RESET: pll_rst=1 for exactly PLL_RST_CYCLES cycles, locked ignored, then -> WAIT_LOCK with timeout counter cleared.
REQ-022 Lock loss in STABLE or STAGGER SHALL NOT increment lock_lost_count.
REQ-023 rst_video SHALL never be 0 while rst_core is 1.
REQ-024 Counters SHALL be sized with $clog2 of their parameter and SHALL NOT wrap in any state.
REQ-025 Release latency from a clean locked rise: rst_core falls SYNC_STAGES+STABLE_CYCLES edges later (+/-1 for metastability); rst_video falls STAGGER_CYCLES edges after rst_core.

Reset
REQ-026 reset SHALL asynchronously clear every flop including the synchronizer: state=WAIT_LOCK, rst_core=rst_video=1, pll_rst=0, ready=0, lock_lost_count=0, counters=0.
REQ-027 reset asserted mid-operation (any state, including a PLL_RESET pulse) SHALL immediately force the REQ-026 values; deassertion SHALL restart from WAIT_LOCK.

Structure
REQ-028 State encodings and parameter default constants SHALL live in shared package pll_reset_pkg.
REQ-029 The synchronizer SHALL be sub-module sync_ff (parameterized depth, async active-high reset).

Verification (SYNC_STAGES=2, STABLE_CYCLES=16, STAGGER_CYCLES=4, RELOCK_TIMEOUT=64, PLL_RST_CYCLES=8)
REQ-030 Release reset, raise locked at cycle 10 -> rst_core falls at cycle 28+/-1, rst_video and ready rise/fall at cycle 32+/-1, count=0.
REQ-031 Keep locked low -> pll_rst high for exactly 8 cycles starting cycle 64, then WAIT_LOCK; repeats every 72 cycles.
REQ-032 locked glitches low for 1 cycle during STABLE -> stable counter restarts, rst_core held, count stays 0.
REQ-033 In RUN drop locked for 3 cycles, 300 times -> each drop reasserts both resets within 3 edges, count saturates at 255.
REQ-034 Assert reset during PLL_RESET and during RUN -> pll_rst=0, rst_core=rst_video=1, ready=0 without waiting for a clock edge.
